// File: rtl/alu_pkg.sv
// Shared opcodes, widths and payload types for the ALU issue pipeline.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_MUL  = 4'h2;
   localparam logic [3:0] ALU_DIV  = 4'h3;
   localparam logic [3:0] ALU_SHL  = 4'h4;
   localparam logic [3:0] ALU_SHR  = 4'h5;
   localparam logic [3:0] ALU_ROL  = 4'h6;
   localparam logic [3:0] ALU_ROR  = 4'h7;
   localparam logic [3:0] ALU_AND  = 4'h8;
   localparam logic [3:0] ALU_OR   = 4'h9;
   localparam logic [3:0] ALU_XOR  = 4'hA;
   localparam logic [3:0] ALU_NOR  = 4'hB;
   localparam logic [3:0] ALU_NAND = 4'hC;
   localparam logic [3:0] ALU_XNOR = 4'hD;
   localparam logic [3:0] ALU_GT   = 4'hE;
   localparam logic [3:0] ALU_EQ   = 4'hF;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic dz;
   } alu_flags_t;

   typedef struct packed {
      logic [3:0]       sel;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
   } op_req_t;

   typedef struct packed {
      logic [3:0]       sel;
      alu_flags_t       flags;
      logic [ALU_W-1:0] result;
   } op_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; carry is add carry-out, sub borrow, or mul overflow.
module alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [3:0]       sel,
   output logic [ALU_W-1:0] out,
   output logic             carry
);

   logic [ALU_W:0]     sum;
   logic [ALU_W:0]     diff;
   logic [2*ALU_W-1:0] prod;
   logic [4:0]         sh;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign prod = {32'b0, a} * {32'b0, b};
   assign sh   = b[4:0];

   always_comb begin
      out   = '0;
      carry = 1'b0;
      case (sel)
         ALU_ADD:  begin out = sum[ALU_W-1:0];  carry = sum[ALU_W];  end
         ALU_SUB:  begin out = diff[ALU_W-1:0]; carry = diff[ALU_W]; end
         ALU_MUL:  begin out = prod[ALU_W-1:0]; carry = |prod[2*ALU_W-1:ALU_W]; end
         ALU_DIV:  out = (b == '0) ? '0 : a / b;
         ALU_SHL:  out = a << sh;
         ALU_SHR:  out = a >> sh;
         ALU_ROL:  out = (sh == 5'd0) ? a : ((a << sh) | (a >> (6'd32 - {1'b0, sh})));
         ALU_ROR:  out = (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
         ALU_AND:  out = a & b;
         ALU_OR:   out = a | b;
         ALU_XOR:  out = a ^ b;
         ALU_NOR:  out = ~(a | b);
         ALU_NAND: out = ~(a & b);
         ALU_XNOR: out = ~(a ^ b);
         ALU_GT:   out = {31'b0, (a > b)};
         ALU_EQ:   out = {31'b0, (a == b)};
         default:  out = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage_pipe_reg.sv
// Generic one-entry valid/ready pipeline register with synchronous clear.
module alu_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic adv;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (adv)
            out_valid <= in_valid;
         // payload only moves on a real transfer, so stale data survives a flush
         if (in_valid && in_ready)
            out_data <= in_data;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue wrapper around an external ALU: operand register, then result/flag register.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int               CNT_W     = 16,
   parameter logic [ALU_W-1:0] DZ_RESULT = 32'hFFFF_FFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ALU_W-1:0] in_a,
   input  logic [ALU_W-1:0] in_b,
   input  logic [3:0]       in_sel,
   output logic [ALU_W-1:0] alu_a,
   output logic [ALU_W-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [ALU_W-1:0] alu_out,
   input  logic             alu_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ALU_W-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_dz,
   output logic [3:0]       out_sel,
   output logic [CNT_W-1:0] op_count
);

   op_req_t          s1_in, s1_q;
   op_rsp_t          s2_in, s2_q;
   logic             s1_valid;
   logic             s2_ready;
   logic             dz;
   logic [ALU_W-1:0] result;

   assign s1_in = '{sel: in_sel, a: in_a, b: in_b};

   alu_pipe_reg #(.W($bits(op_req_t))) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_q)
   );

   assign alu_a   = s1_q.a;
   assign alu_b   = s1_q.b;
   assign alu_sel = s1_q.sel;

   // Flags are derived from the substituted result, not the raw ALU output.
   assign dz     = (alu_sel == ALU_DIV) && (alu_b == '0);
   assign result = dz ? DZ_RESULT : alu_out;

   always_comb begin
      s2_in              = '0;
      s2_in.sel          = alu_sel;
      s2_in.result       = result;
      s2_in.flags.carry  = dz ? 1'b0 : alu_carry;
      s2_in.flags.zero   = (result == '0);
      s2_in.flags.neg    = result[ALU_W-1];
      s2_in.flags.dz     = dz;
   end

   alu_pipe_reg #(.W($bits(op_rsp_t))) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_q)
   );

   assign out_result = s2_q.result;
   assign out_carry  = s2_q.flags.carry;
   assign out_zero   = s2_q.flags.zero;
   assign out_neg    = s2_q.flags.neg;
   assign out_dz     = s2_q.flags.dz;
   assign out_sel    = s2_q.sel;

   // Counts consumed results even on a flush edge; wraps freely.
   always_ff @(posedge clk) begin
      if (!rst_n)
         op_count <= '0;
      else if (out_valid && out_ready)
         op_count <= op_count + 1'b1;
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage driven against the real ALU.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [3:0]  sel;
      logic        dz;
      logic        n;
      logic        z;
      logic        c;
      logic [31:0] r;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_sel;
   logic        in_ready, out_valid, out_carry, out_zero, out_neg, out_dz;
   logic [31:0] alu_a, alu_b, alu_out, out_result;
   logic [3:0]  alu_sel, out_sel;
   logic        alu_carry;
   logic [15:0] op_count;
   logic        in_ready4, out_valid4, out_carry4, out_zero4, out_neg4, out_dz4;
   logic [31:0] alu_a4, alu_b4, out_result4;
   logic [3:0]  alu_sel4, out_sel4;
   logic [3:0]  op_count4;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cnt_ref = 0;
   res_t inflight[$];
   res_t exp_q[$];
   res_t got_q[$];

   always #5 clk = ~clk;

   alu u_alu (.a(alu_a), .b(alu_b), .sel(alu_sel), .out(alu_out), .carry(alu_carry));

   alu_issue_stage u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg), .out_dz(out_dz),
      .out_sel(out_sel), .op_count(op_count)
   );

   // Narrow-counter copy fed identical inputs; its ALU request equals u_dut's.
   alu_issue_stage #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_out(alu_out), .alu_carry(alu_carry),
      .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
      .out_carry(out_carry4), .out_zero(out_zero4), .out_neg(out_neg4), .out_dz(out_dz4),
      .out_sel(out_sel4), .op_count(op_count4)
   );

   function automatic res_t ref_op(logic [3:0] s, logic [31:0] a, logic [31:0] b);
      res_t        x;
      logic [63:0] w;
      int          sh;
      x = '0;
      x.sel = s;
      sh = int'(b % 32);
      case (s)
         4'h0: begin w = {32'b0, a} + {32'b0, b}; x.r = w[31:0]; x.c = w[32]; end
         4'h1: begin x.r = a - b; x.c = (a < b); end
         4'h2: begin w = {32'b0, a} * {32'b0, b}; x.r = w[31:0]; x.c = (w >> 32) != 0; end
         4'h3: if (b == 0) begin x.r = 32'hFFFF_FFFF; x.dz = 1'b1; end else x.r = a / b;
         4'h4: x.r = a << sh;
         4'h5: x.r = a >> sh;
         4'h6: begin w = {a, a} << sh; x.r = w[63:32]; end
         4'h7: begin w = {a, a} >> sh; x.r = w[31:0]; end
         4'h8: x.r = a & b;
         4'h9: x.r = a | b;
         4'hA: x.r = a ^ b;
         4'hB: x.r = ~(a | b);
         4'hC: x.r = ~(a & b);
         4'hD: x.r = ~(a ^ b);
         4'hE: x.r = (a > b) ? 32'd1 : 32'd0;
         default: x.r = (a == b) ? 32'd1 : 32'd0;
      endcase
      x.z = (x.r == 0);
      x.n = x.r[31];
      return x;
   endfunction

   // Transaction-level model: ops in flight, results consumed, consumed count.
   always @(negedge clk) begin
      if (!rst_n) begin
         inflight.delete();
         cnt_ref = 0;
      end else begin
         if (out_valid && out_ready) begin
            got_q.push_back('{sel: out_sel, dz: out_dz, n: out_neg, z: out_zero, c: out_carry, r: out_result});
            if (inflight.size() > 0) exp_q.push_back(inflight.pop_front());
            else exp_q.push_back('x);
            cnt_ref++;
         end
         if (flush) inflight.delete();
         else if (in_valid && in_ready) inflight.push_back(ref_op(in_sel, in_a, in_b));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      int k = 0;
      in_sel = s; in_a = a; in_b = b; in_valid = 1'b1;
      #1;
      while (in_ready !== 1'b1 && k < 50) begin step(); k++; end
      n_chk++;
      if (k == 50) begin n_fail++; $display("FAIL send_timeout: in_ready=%b required 1", in_ready); end
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_sel = '0;
      step(); step();
      n_chk += 6;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result: got %h required 0", out_result); end
      if ({out_carry, out_zero, out_neg, out_dz, out_sel} !== 8'd0) begin n_fail++; $display("FAIL reset_flags: got %b required 0", {out_carry, out_zero, out_neg, out_dz, out_sel}); end
      if ({alu_a, alu_b, alu_sel} !== 68'd0) begin n_fail++; $display("FAIL reset_alu_regs: got %h required 0", {alu_a, alu_b, alu_sel}); end
      if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d required 0", op_count); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_op();
      out_ready = 1'b1;
      send(4'h0, 32'hFFFF_FFFF, 32'd1);
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b required 0", out_valid); end
      step();
      n_chk += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b required 1", out_valid); end
      if (out_result !== 32'd0) begin n_fail++; $display("FAIL single_result: got %h required 0", out_result); end
      if ({out_carry, out_zero, out_neg, out_dz, out_sel} !== {4'b1100, 4'h0}) begin
         n_fail++; $display("FAIL single_flags: got %b required 11000000", {out_carry, out_zero, out_neg, out_dz, out_sel});
      end
      step();
      n_chk++;
      if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_op_count: got %0d required 1", op_count); end
   endtask

   task automatic test_div_zero();
      out_ready = 1'b1;
      send(4'h3, 32'd100, 32'd0);
      step();
      n_chk += 4;
      if (out_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_result: got %h required ffffffff", out_result); end
      if (out_dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b required 1", out_dz); end
      if (out_carry !== 1'b0) begin n_fail++; $display("FAIL dz_carry: got %b required 0", out_carry); end
      if (out_neg !== 1'b1) begin n_fail++; $display("FAIL dz_neg: got %b required 1", out_neg); end
      step();
      send(4'h3, 32'd100, 32'd7);
      step();
      n_chk += 2;
      if (out_result !== 32'd14) begin n_fail++; $display("FAIL div_result: got %0d required 14", out_result); end
      if (out_dz !== 1'b0) begin n_fail++; $display("FAIL div_dz: got %b required 0", out_dz); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(4'h1, 32'd5, 32'd3);
      send(4'hA, 32'hF0F0_F0F0, 32'hFFFF_0000);
      in_sel = 4'h0; in_a = 32'd7; in_b = 32'd8; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_chk += 3;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
         if (out_result !== 32'd2 || out_sel !== 4'h1) begin n_fail++; $display("FAIL bp_hold: got %h/%h required 2/1", out_result, out_sel); end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b1 || out_result !== 32'h0F0F_F0F0) begin n_fail++; $display("FAIL bp_second: got %b/%h required 1/0f0ff0f0", out_valid, out_result); end
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_result !== 32'd15) begin n_fail++; $display("FAIL bp_third: got %b/%0d required 1/15", out_valid, out_result); end
      step();
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b required 0", out_valid); end
   endtask

   task automatic test_streaming();
      int start, k;
      got_q.delete(); exp_q.delete();
      start = cnt_ref;
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 64; i++) begin
         in_sel = 4'($urandom);
         in_a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
         in_b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
         in_valid = 1'b1;
         n_chk++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b required 1", i, in_ready); end
         if (i >= 2) begin
            n_chk++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d]: got %b required 1", i, out_valid); end
         end
         step();
      end
      in_valid = 1'b0;
      k = 0;
      while (got_q.size() < 64 && k < 10) begin step(); k++; end
      n_chk++;
      if (got_q.size() != 64) begin n_fail++; $display("FAIL stream_count: got %0d required 64", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_result[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      n_chk += 2;
      if (op_count !== 16'(start + 64)) begin n_fail++; $display("FAIL stream_op_count: got %0d required %0d", op_count, 16'(start + 64)); end
      if (op_count4 !== 4'(start + 64)) begin n_fail++; $display("FAIL stream_op_count4: got %0d required %0d", op_count4, 4'(start + 64)); end
   endtask

   task automatic test_flush();
      logic [15:0] c0;
      out_ready = 1'b0;
      send(4'h0, 32'd1, 32'd1);
      send(4'h0, 32'd2, 32'd2);
      c0 = op_count;
      flush = 1'b1; in_sel = 4'h0; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_chk += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b required 0", out_valid); end
      if (op_count !== c0) begin n_fail++; $display("FAIL flush_op_count: got %0d required %0d", op_count, c0); end
      step();
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b required 0", out_valid); end
      send(4'h0, 32'd3, 32'd4);
      send(4'h0, 32'd5, 32'd6);
      c0 = op_count;
      out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0;
      n_chk += 2;
      if (op_count !== c0 + 16'd1) begin n_fail++; $display("FAIL flush_hs_count: got %0d required %0d", op_count, c0 + 16'd1); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hs_valid: got %b required 0", out_valid); end
      send(4'h0, 32'd1, 32'd2);
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_result !== 32'd3) begin n_fail++; $display("FAIL flush_after: got %b/%0d required 1/3", out_valid, out_result); end
      step();
   endtask

   task automatic test_wrap();
      out_ready = 1'b0;
      send(4'h2, 32'd6, 32'd7);
      send(4'h9, 32'd1, 32'd2);
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid[%0d]: got %b required 0", i, out_valid); end
         step();
      end
      for (int i = 0; i < 17; i++) begin
         in_sel = 4'($urandom); in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_chk += 2;
      if (op_count4 !== 4'd1) begin n_fail++; $display("FAIL wrap_op_count4: got %0d required 1", op_count4); end
      if (op_count !== 16'd17) begin n_fail++; $display("FAIL wrap_op_count: got %0d required 17", op_count); end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_div_zero();
      test_backpressure();
      test_streaming();
      test_flush();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
